// File: rtl/mult_pkg.sv
// Shared definitions for the sequential MULT/MULTU unit: FSM states,
// default sizing and the decode funct codes that select it.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: operand magnitudes, the 2*WIDTH accumulator and the
// sign fix-up of the finished product. Sequenced by load/step from the FSM.
module mult_shift_add_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  output logic [2*WIDTH-1:0] product_o
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     sum;

  // Magnitudes are unsigned WIDTH-bit, so the most negative value maps to 2**(WIDTH-1).
  always_comb begin
    mag1 = (signed_i & src1_i[WIDTH-1]) ? -src1_i : src1_i;
    mag2 = (signed_i & src2_i[WIDTH-1]) ? -src2_i : src2_i;
    sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  end

  // The multiplier sits in the low half and shifts out as the product shifts in.
  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    if (load_i) begin
      mcand_d = mag1;
      acc_d   = {{WIDTH{1'b0}}, mag2};
      neg_d   = signed_i & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
    end else if (step_i) begin
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
    end
  end

  assign product_o = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for multi-cycle MULT/MULTU: FSM, iteration counter, pipeline
// stall and the HI/LO registers written when the product is ready.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               accept, lastIter, load, step;
  logic [2*WIDTH-1:0] product;

  assign accept   = start_i & ~flush_i;
  assign lastIter = (cnt_q == CNT_W'(WIDTH-1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (flush_i)       state_d = IDLE;
        else if (lastIter) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DONE writes regardless of flush: the instruction has already committed.
  always_comb begin
    {hi_d, lo_d} = {hi_q, lo_q};
    if (state_q == DONE) {hi_d, lo_d} = product;
  end

  always_comb begin
    busy_o  = (state_q != IDLE);
    done_o  = (state_q == DONE);
    load    = (state_q == IDLE) & accept;
    step    = (state_q == CALC);
    stall_o = load | step;
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  mult_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (load),
    .step_i   (step),
    .signed_i (signed_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .product_o(product)
  );

endmodule
